// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-output reset generator.
// The async board reset is synchronised on release. All outputs are held asserted for
// HOLD_CYCLES, then released one at a time, lowest index first, STAGGER_CYCLES apart.
// Optional feature macro: RSTSEQ_SOFT_RST_EN. When it is defined, soft_rst_req re-runs
// the sequence without a board reset. When it is not defined, soft_rst_req is ignored.

module reset_sequencer #(
   parameter int NUM_OUT        = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               soft_rst_req,
   output logic [NUM_OUT-1:0] rst_out,
   output logic               rst_done
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_OUT + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
   // Index of the output released just before the final one; only meaningful for NUM_OUT > 1.
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((NUM_OUT > 1) ? NUM_OUT - 2 : 0);

   // Elaboration-time parameter range checks.
   if (NUM_OUT < 1) begin : g_bad_num_out
      $error("reset_sequencer: NUM_OUT must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("reset_sequencer: SYNC_STAGES must be >= 2");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
   end
   if (STAGGER_CYCLES < 1) begin : g_bad_stagger_cycles
      $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Release synchroniser: set asynchronously by arst, and shifts in 0s once arst is low.
   // ------------------------------------------------------------------
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   arst_sync;

   // Shift a 0 into stage 0 and move the chain up by one stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   // Synchroniser flops. arst sets them immediately, so even a sub-cycle pulse restarts the chain.
   // NOTE: registers take non-blocking (<=) assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign arst_sync = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Soft reset request (already synchronous to clk, so it needs no synchroniser).
   // ------------------------------------------------------------------
   logic soft_req;

`ifdef RSTSEQ_SOFT_RST_EN
   assign soft_req = soft_rst_req;
`else
   logic soft_unused;
   assign soft_unused = soft_rst_req;
   assign soft_req    = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Sequencing FSM with registered outputs.
   // ------------------------------------------------------------------
   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [NUM_OUT-1:0] rst_out_q,  rst_out_d;
   logic               rst_done_q, rst_done_d;

   // Next-state logic: hold count, staggered releases and the soft restart.
   // NOTE: every _d signal gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rst_out_d  = rst_out_q;
      rst_done_d = rst_done_q;

      if (soft_req) begin
         // A soft request takes priority over any release due on the same edge.
         state_d    = ST_HOLD;
         cnt_d      = '0;
         idx_d      = '0;
         rst_out_d  = '1;
         rst_done_d = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (arst_sync) begin
                  cnt_d = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  rst_out_d[0] = 1'b0;
                  idx_d        = '0;
                  cnt_d        = '0;
                  state_d      = (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_RELEASE: begin
               if (cnt_q == STAG_LAST) begin
                  cnt_d = '0;
                  idx_d = idx_q + IDX_W'(1);
                  // Release the output that follows the most recently released one.
                  for (int i = 1; i < NUM_OUT; i++) begin
                     if (idx_q == IDX_W'(i - 1)) begin
                        rst_out_d[i] = 1'b0;
                     end
                  end
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_DONE: begin
               rst_done_d = 1'b1;
            end

            default: begin
               state_d    = ST_HOLD;
               cnt_d      = '0;
               idx_d      = '0;
               rst_out_d  = '1;
               rst_done_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers. arst forces all outputs asserted and restarts from HOLD.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_out_q  <= '1;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_out_q  <= rst_out_d;
         rst_done_q <= rst_done_d;
      end
   end

   assign rst_out  = rst_out_q;
   assign rst_done = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard testbench for reset_sequencer.
// The reference model tracks one quantity, t: the number of qualifying edges since the
// last restart. An edge qualifies once the synchroniser has cleared and no soft request
// is sampled on it. Output i is released once t >= HOLD + i*STAGGER, and rst_done is set
// once t >= HOLD + (N-1)*STAGGER + 1.
// Two instances run side by side: one with the default parameters, and one with
// NUM_OUT=1, HOLD=1 and STAGGER=1.

module tb_reset_sequencer;

   localparam int S  = 2;
   localparam int H4 = 16;
   localparam int G4 = 4;
   localparam int H1 = 1;
   localparam int G1 = 1;

`ifdef RSTSEQ_SOFT_RST_EN
   localparam bit SOFT_EN = 1'b1;
`else
   localparam bit SOFT_EN = 1'b0;
`endif

   logic       clk;
   logic       arst;
   logic       soft_rst_req;
   logic [3:0] rst_out4;
   logic       rst_done4;
   logic [0:0] rst_out1;
   logic       rst_done1;

   reset_sequencer #(
      .NUM_OUT(4), .SYNC_STAGES(S), .HOLD_CYCLES(H4), .STAGGER_CYCLES(G4)
   ) u_dut4 (
      .clk          (clk),
      .arst         (arst),
      .soft_rst_req (soft_rst_req),
      .rst_out      (rst_out4),
      .rst_done     (rst_done4)
   );

   reset_sequencer #(
      .NUM_OUT(1), .SYNC_STAGES(S), .HOLD_CYCLES(H1), .STAGGER_CYCLES(G1)
   ) u_dut1 (
      .clk          (clk),
      .arst         (arst),
      .soft_rst_req (soft_rst_req),
      .rst_out      (rst_out1),
      .rst_done     (rst_done1)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [3:0] out4;
      logic       done4;
      logic       out1;
      logic       done1;
      int         tag;
   } exp_t;

   exp_t sb_q[$];
   event sample_ev;
   int   checks   = 0;
   int   failures = 0;

   // Reference model state.
   int e_cnt = 0;   // edges since arst was released
   int t_cnt = 0;   // qualifying edges since the last restart

   // Expected outputs of both instances after t qualifying edges.
   function automatic exp_t model_exp(int t, int tag);
      exp_t x;
      for (int i = 0; i < 4; i++) x.out4[i] = (t < H4 + i * G4);
      x.done4 = (t >= H4 + 3 * G4 + 1);
      x.out1  = (t < H1);
      x.done1 = (t >= H1 + 1);
      x.tag   = tag;
      return x;
   endfunction

   // Advance the model by one clk edge, using the soft request sampled on that edge.
   task automatic model_edge();
      e_cnt++;
      if (SOFT_EN && soft_rst_req) t_cnt = 0;
      else if (e_cnt > S)          t_cnt++;
   endtask

   task automatic check(string name, int tag, logic [4:0] act, logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s tag=%0d actual={done,out}=%h expected=%h at %0t", name, tag, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation on each falling edge or async sample point, then compares.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk or sample_ev);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("seq4", x.tag, {rst_done4, rst_out4}, {x.done4, x.out4});
            check("seq1", x.tag, {3'b000, rst_done1, rst_out1}, {3'b000, x.done1, x.out1});
         end
      end
   end

   // One clock edge with a per-cycle expectation that is checked at the next falling edge.
   task automatic do_step(int tag);
      @(posedge clk);
      #1;
      model_edge();
      sb_q.push_back(model_exp(t_cnt, tag));
   endtask

   // Check the state after the edge, then pulse arst for 3 time units between edges.
   // The asserted state is checked while the pulse is high.
   task automatic arst_pulse(int tag);
      @(posedge clk);
      #1;
      model_edge();
      sb_q.push_back(model_exp(t_cnt, tag));
      -> sample_ev;
      #1 arst = 1'b1;
      e_cnt = 0;
      t_cnt = 0;
      #1;
      sb_q.push_back(model_exp(0, tag + 1000));
      -> sample_ev;
      #2 arst = 1'b0;
   endtask

   initial begin
      arst         = 1'b1;
      soft_rst_req = 1'b0;

      // Reset state while arst is held high.
      repeat (2) @(posedge clk);
      #2;
      sb_q.push_back(model_exp(0, 0));
      -> sample_ev;
      #3 arst = 1'b0;
      e_cnt = 0;
      t_cnt = 0;

      // Free run from release into DONE.
      repeat (40) do_step(1);

      // Sub-cycle arst pulse while in DONE, then the full sequence again.
      arst_pulse(2);
      repeat (40) do_step(3);

      // arst re-asserted right after edge 24 (rst_out=4'hC), then a restart.
      arst_pulse(3);
      repeat (23) do_step(4);
      arst_pulse(5);
      repeat (40) do_step(6);

      // Soft request held for 5 sampled edges while in DONE.
      soft_rst_req = 1'b1;
      repeat (5) do_step(7);
      soft_rst_req = 1'b0;
      repeat (35) do_step(8);

      // Soft request landing on the edge that would release output 1.
      soft_rst_req = 1'b1;
      do_step(9);
      soft_rst_req = 1'b0;
      repeat (19) do_step(10);
      soft_rst_req = 1'b1;
      do_step(11);
      soft_rst_req = 1'b0;
      repeat (40) do_step(12);

      // Randomised mix of arst pulses and soft request toggles.
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 4) begin
            arst_pulse(20);
         end else begin
            if (r < 40) soft_rst_req = ~soft_rst_req;
            do_step(21);
         end
      end
      soft_rst_req = 1'b0;
      repeat (40) do_step(22);

      // Drain the scoreboard within a bounded number of cycles.
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
